// File: rtl/muldiv_sequencer_pkg.sv
// Purpose: shared types, code constants and latency select for the mul/div sequencer.
// Latency: n/a (types and a pure combinational function only).
// Backpressure: n/a.
package muldiv_sequencer_pkg;

    // Reset level and register address width shared with the rest of the core.
    localparam logic RESET = 1'b1;
    typedef logic [4:0] RegAddr;

    // Mul/div operation codes; bit 2 set means a divide/remainder op.
    typedef logic [2:0] MulDivCode;
    localparam MulDivCode MD_MUL    = 3'd0;
    localparam MulDivCode MD_MULH   = 3'd1;
    localparam MulDivCode MD_MULHSU = 3'd2;
    localparam MulDivCode MD_MULHU  = 3'd3;
    localparam MulDivCode MD_DIV    = 3'd4;
    localparam MulDivCode MD_DIVU   = 3'd5;
    localparam MulDivCode MD_REM    = 3'd6;
    localparam MulDivCode MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } MulDivSeqState;

    // Number of stalled execute cycles an op needs before its result cycle.
    // A divide by zero resolves in a single cycle regardless of the divider depth.
    function automatic int unsigned mulDivLatency(
        input MulDivCode   code,
        input logic        op2_zero,
        input int unsigned mul_lat,
        input int unsigned div_lat
    );
        int unsigned lat;
        if (code[2] && op2_zero) begin
            lat = 1;
        end else if (code[2]) begin
            lat = div_lat;
        end else begin
            lat = mul_lat;
        end
        return lat;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_counter.sv
// Purpose: loadable down-counter with zero detect that times the mul/div op.
// Latency: load and decrement take effect at the next rising edge; zero flag is combinational.
// Backpressure: none; decrement saturates at zero while enabled.
module muldiv_sequencer_counter
    import muldiv_sequencer_pkg::*;
#(
    parameter int CNT_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_en,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 dec_en,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 cnt_zero
);

    // Load wins over decrement so a back-to-back issue restarts the count cleanly.
    always_ff @(posedge clk) begin
        if (rst == RESET) begin
            cnt <= '0;
        end else if (load_en) begin
            cnt <= load_val;
        end else if (dec_en && !cnt_zero) begin
            cnt <= cnt - CNT_WIDTH'(1);
        end
    end

    assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// Purpose: issues mul/div ops to the unit, stalls the pipeline for the op latency, flags the result cycle.
// Latency: issue at cycle t, stall t+1..t+L, result valid at t+L+1; back-to-back issue has no bubble.
// Backpressure: hold keeps the result cycle (and blocks new issue); flush aborts and wins over issue.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 2,
    parameter int unsigned DIV_LATENCY = 33,
    parameter int          CNT_WIDTH   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issueValid,
    input  logic [2:0]  issueCode,
    input  logic [4:0]  issueRd,
    input  logic        issueOp2Zero,
    input  logic        hold,
    input  logic        flush,
    output logic        unitStart,
    output logic        unitClear,
    output logic [2:0]  unitCode,
    output logic        stallReq,
    output logic        resultValid,
    output logic        busyValid,
    output logic [4:0]  busyRd,
    output logic [31:0] opCount
);

    MulDivSeqState        state_q;
    MulDivSeqState        state_nxt;
    MulDivCode            code_q;
    RegAddr               rd_q;
    logic                 issue_fire;
    logic                 done_release;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 cnt_zero;
    logic [CNT_WIDTH-1:0] load_val;
    int unsigned          issue_lat;

    // Counter is loaded with L-1 so that cnt==0 marks the last stalled cycle.
    always_comb begin
        issue_lat = mulDivLatency(issueCode, issueOp2Zero, MUL_LATENCY, DIV_LATENCY);
        load_val  = CNT_WIDTH'(issue_lat - 1);
    end

    muldiv_sequencer_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .load_en  (issue_fire),
        .load_val (load_val),
        .dec_en   (state_q == RUN),
        .cnt      (cnt),
        .cnt_zero (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst == RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state and control outputs; flush overrides everything, reset suppresses the unit pulses.
    always_comb begin
        state_nxt    = state_q;
        issue_fire   = 1'b0;
        done_release = 1'b0;
        unitClear    = 1'b0;
        stallReq     = 1'b0;
        resultValid  = 1'b0;
        busyValid    = 1'b0;
        case (state_q)
            IDLE: begin
                if (issueValid) begin
                    issue_fire = 1'b1;
                    state_nxt  = RUN;
                end
            end
            RUN: begin
                stallReq  = 1'b1;
                busyValid = 1'b1;
                if (cnt_zero) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                resultValid = 1'b1;
                busyValid   = 1'b1;
                if (!hold) begin
                    done_release = 1'b1;
                    if (issueValid) begin
                        issue_fire = 1'b1;
                        state_nxt  = RUN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (flush) begin
            state_nxt    = IDLE;
            issue_fire   = 1'b0;
            done_release = 1'b0;
            resultValid  = 1'b0;
            unitClear    = (state_q != IDLE);
        end
        if (rst == RESET) begin
            issue_fire   = 1'b0;
            done_release = 1'b0;
            unitClear    = 1'b0;
        end
    end

    assign unitStart = issue_fire;

    // Latch the op identity at issue; it drives the unit and the hazard port while in flight.
    always_ff @(posedge clk) begin
        if (rst == RESET) begin
            code_q <= '0;
            rd_q   <= '0;
        end else if (issue_fire) begin
            code_q <= issueCode;
            rd_q   <= issueRd;
        end
    end

    // Completed-op counter bumps only when a result cycle is released downstream.
    always_ff @(posedge clk) begin
        if (rst == RESET) begin
            opCount <= '0;
        end else if (done_release) begin
            opCount <= opCount + 32'd1;
        end
    end

    // The unit sees the new code in the issue cycle itself, before it is latched.
    always_comb begin
        busyRd   = busyValid ? rd_q : '0;
        unitCode = issue_fire ? issueCode : (busyValid ? code_q : '0);
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

- Sequences the multi-cycle multiply/divide unit in the execute stage.
- Detects a mul/div op leaving decode and pulses the unit's start.
- Counts the op-dependent latency, holds execute and all earlier stages with a stall request until the result is ready, then releases the pipeline for one result cycle.
- Sits between the decode-stage output, the pipeline controller (stall/flush) and the mul/div unit (start/clear/code).

## Interface
Parameters:
- MUL_LATENCY, 2, execute cycles a MUL* op holds the stage before its result cycle (≥1)
- DIV_LATENCY, 33, same for DIV*/REM* (≥1)
- CNT_WIDTH, 6, latency counter width; must hold max(MUL_LATENCY, DIV_LATENCY)-1

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high (RESET constant)
- issueValid  in  1  decode output is a mul/div op and advances into execute at this edge
- issueCode  in  3  MulDivCode of that op (0-3 MUL/MULH/MULHSU/MULHU, 4-7 DIV/DIVU/REM/REMU)
- issueRd  in  5  destination register of that op
- issueOp2Zero  in  1  divisor is zero (fast path, divide codes only)
- hold  in  1  downstream stall on execute from another source
- flush  in  1  kill execute-stage contents (branch mispredict)
- unitStart  out  1  one-cycle start pulse to the mul/div unit
- unitClear  out  1  one-cycle abort pulse to the mul/div unit
- unitCode  out  3  latched code driven to the unit
- stallReq  out  1  hold execute and earlier stages
- resultValid  out  1  mul/div result at execute output is valid this cycle
- busyValid  out  1  an op is in flight (RUN or DONE)
- busyRd  out  5  rd of the in-flight op, for hazard detection
- opCount  out  32  completed-op counter, wraps

## Operation
States IDLE, RUN, DONE. Reset: IDLE, cnt 0, all outputs 0, opCount 0.
- Latency L: divide code with issueOp2Zero → 1; code[2]=1 → DIV_LATENCY; else MUL_LATENCY.
- Issue (IDLE or DONE-with-release, issueValid=1, flush=0):
  - unitStart=1 combinationally.
  - Latch code and rd; cnt ← L-1; next state RUN.
- RUN: stallReq=1, busyValid=1. If cnt==0 → DONE, else cnt ← cnt-1. issueValid ignored.
- DONE: resultValid=1, stallReq=0, busyValid=1.
  - hold=1: remain DONE, outputs unchanged, issueValid ignored.
  - hold=0: opCount ← opCount+1. Next state RUN if issueValid (back-to-back issue), else IDLE.
- flush in any state:
  - Next state IDLE; unitClear=1 if state ≠ IDLE.
  - resultValid forced 0 that cycle; no opCount increment.
  - Same-cycle issueValid is discarded (flush wins).
- busyRd holds the latched rd while busyValid; otherwise 0.
- unitCode holds the latched code while busyValid, and shows issueCode during the issue cycle.

## Timing
- Issue edge at cycle t. RUN occupies t+1…t+L. DONE at t+L+1.
- Op sits in execute for L+1 cycles, of which L are stalled.
- Back-to-back issue: zero bubble, since DONE→RUN happens at the release edge.
- unitStart and unitClear are combinational single-cycle pulses. All state changes occur on the rising edge.
- A reset asserted mid-RUN returns the block to IDLE at the next edge with no unitClear. The unit is reset by the same rst.
- A flush during the last RUN cycle (cnt==0) still aborts; DONE is never entered.

## Structure
- PipelineTypes: MulDivCode typedef and code constants; MulDivSeqState enum (IDLE, RUN, DONE).
- BasicTypes: RESET, RegAddr (5-bit).
- Latency select is one small combinational function in the package (mulDivLatency).
- Sub-module: MulDivLatencyCounter. Handles load/decrement/zero-detect of cnt, with a load value and an enable.

## Test plan
- MUL issue, L=2: unitStart pulse at t. stallReq high t+1..t+2. resultValid at t+3. opCount=1.
- DIVU, issueOp2Zero=0: stallReq for exactly 33 cycles, then resultValid 1 cycle. DIVU with issueOp2Zero=1: stallReq 1 cycle.
- Back-to-back MUL then DIV, issued in DONE with hold=0: no IDLE cycle between them. busyRd changes to the second rd at the DONE→RUN edge. opCount=2 after the second DONE.
- hold=1 for 3 cycles in DONE: resultValid stays high 4 cycles. issueValid during hold is ignored. opCount increments once.
- flush at RUN cycle 10 of a DIV: unitClear pulse, IDLE next cycle, no resultValid, opCount unchanged. flush together with issueValid in IDLE: no unitStart.
- rst asserted mid-RUN: next cycle all outputs 0, IDLE. A new MUL issued afterwards completes normally.
